// File: rtl/cpu_trap_pkg.sv
// Shared definitions for the supervisor trap sequencer: state encoding,
// sstatus update opcodes, interrupt codes and stvec mode.
package cpu_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_JUMP = 2'd2,
    ST_RET  = 2'd3
  } trap_state_e;

  localparam logic [1:0] STATUS_OP_NONE   = 2'b00;
  localparam logic [1:0] STATUS_OP_ENTER  = 2'b01;
  localparam logic [1:0] STATUS_OP_RETURN = 2'b10;

  localparam logic [4:0] IRQ_SSI = 5'd1;
  localparam logic [4:0] IRQ_STI = 5'd5;
  localparam logic [4:0] IRQ_SEI = 5'd9;

  localparam logic [1:0] STVEC_MODE_VECTORED = 2'b01;

  function automatic logic [31:0] irq_cause(input logic [4:0] code);
    return {1'b1, 26'b0, code};
  endfunction

  // Vector offset only applies to interrupts in vectored mode; wraps mod 2^32.
  function automatic logic [31:0] trap_target(input logic [31:0] stvec,
                                              input logic [31:0] cause);
    logic [31:0] base;
    base = {stvec[31:2], 2'b00};
    if (stvec[1:0] == STVEC_MODE_VECTORED && cause[31])
      return base + {25'b0, cause[4:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/cpu_irq_sync.sv
// Multi-flop synchronizer for an asynchronous level input, cleared on reset.
module cpu_irq_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_trap_ctrl.sv
// Trap sequencer: picks exception / interrupt / sret at an instruction
// boundary, drives the CSR capture strobe and redirects fetch.
module cpu_trap_ctrl
  import cpu_trap_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_done,
  input  logic [31:0] inst_pc,
  input  logic [31:0] inst_next_pc,
  input  logic        exc_req,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_value,
  input  logic        sret_req,
  input  logic        irq_ext,
  input  logic        irq_soft,
  input  logic        irq_timer,
  input  logic        sstatus_sie,
  input  logic [31:0] sie_mask,
  input  logic [31:0] handler_addr,
  input  logic [31:0] continue_addr,
  output logic        trap,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_value,
  output logic [1:0]  status_op,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        stall
);

  trap_state_e state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] value_q, value_d;
  logic        ext_sync;
  logic [31:0] pend;
  logic [31:0] irq_en;

  cpu_irq_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ext_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(irq_ext),
    .sync_o (ext_sync)
  );

  always_comb begin
    pend          = '0;
    pend[IRQ_SEI] = ext_sync;
    pend[IRQ_SSI] = irq_soft;
    pend[IRQ_STI] = irq_timer;
  end

  assign irq_en = pend & sie_mask & {32{sstatus_sie}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      pc_q    <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    pc_d        = pc_q;
    value_d     = value_q;
    trap        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    status_op   = STATUS_OP_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (inst_done) begin
          if (exc_req) begin
            cause_d = {27'b0, exc_cause};
            pc_d    = inst_pc;
            value_d = exc_value;
            state_d = ST_SAVE;
          end else if (irq_en[IRQ_SEI] || irq_en[IRQ_SSI] || irq_en[IRQ_STI]) begin
            if (irq_en[IRQ_SEI])      cause_d = irq_cause(IRQ_SEI);
            else if (irq_en[IRQ_SSI]) cause_d = irq_cause(IRQ_SSI);
            else                      cause_d = irq_cause(IRQ_STI);
            pc_d    = inst_next_pc;
            value_d = '0;
            state_d = ST_SAVE;
          end else if (sret_req) begin
            state_d = ST_RET;
          end
        end
      end
      ST_SAVE: begin
        trap      = 1'b1;
        status_op = STATUS_OP_ENTER;
        state_d   = ST_JUMP;
      end
      ST_JUMP: begin
        redirect    = 1'b1;
        redirect_pc = trap_target(handler_addr, cause_q);
        state_d     = ST_IDLE;
      end
      ST_RET: begin
        redirect    = 1'b1;
        redirect_pc = continue_addr;
        status_op   = STATUS_OP_RETURN;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign trap_cause = cause_q;
  assign trap_pc    = pc_q;
  assign trap_value = value_q;
  assign stall      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Scoreboard bench for cpu_trap_ctrl: directed test-plan cases followed by
// randomized boundaries, checked against a cycle-level reference model.
module tb_cpu_trap_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_done;
  logic [31:0] inst_pc, inst_next_pc;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic [31:0] exc_value;
  logic        sret_req;
  logic        irq_ext, irq_soft, irq_timer;
  logic        sstatus_sie;
  logic [31:0] sie_mask, handler_addr, continue_addr;
  logic        trap, redirect, stall;
  logic [31:0] trap_cause, trap_pc, trap_value, redirect_pc;
  logic [1:0]  status_op;

  cpu_trap_ctrl #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .inst_done(inst_done), .inst_pc(inst_pc),
    .inst_next_pc(inst_next_pc), .exc_req(exc_req), .exc_cause(exc_cause),
    .exc_value(exc_value), .sret_req(sret_req), .irq_ext(irq_ext),
    .irq_soft(irq_soft), .irq_timer(irq_timer), .sstatus_sie(sstatus_sie),
    .sie_mask(sie_mask), .handler_addr(handler_addr),
    .continue_addr(continue_addr), .trap(trap), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_value(trap_value), .status_op(status_op),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    int          cyc;
    logic [31:0] cause, pc, val, tgt;
    logic [1:0]  op;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  free_cyc = 0;
  int  busy_from = 0;
  bit  ext_hist [0:8191];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Reference model: decides what the boundary in the current cycle leads to,
  // then advances one clock.
  task automatic drive_cycle();
    int          c;
    int          code;
    bit          ext_s;
    ev_t         e;
    logic [31:0] base;
    c = cyc;
    ext_hist[c] = irq_ext;
    ext_s = (c >= S) ? ext_hist[c-S] : 1'b0;
    if (!rst && c >= free_cyc && inst_done) begin
      code = -1;
      if (!exc_req && sstatus_sie) begin
        if (ext_s && sie_mask[9])          code = 9;
        else if (irq_soft && sie_mask[1])  code = 1;
        else if (irq_timer && sie_mask[5]) code = 5;
      end
      if (exc_req || code >= 0) begin
        e.is_trap = 1'b1;
        e.cyc     = c + 1;
        e.op      = 2'b01;
        e.tgt     = 32'h0;
        if (exc_req) begin
          e.cause = 32'(exc_cause);
          e.pc    = inst_pc;
          e.val   = exc_value;
        end else begin
          e.cause = 32'h8000_0000 + 32'(code);
          e.pc    = inst_next_pc;
          e.val   = 32'h0;
        end
        sb.push_back(e);
        base      = handler_addr & 32'hFFFF_FFFC;
        e.is_trap = 1'b0;
        e.cyc     = c + 2;
        e.op      = 2'b00;
        e.tgt     = (!exc_req && handler_addr[1:0] == 2'b01) ? base + 32'(code * 4) : base;
        sb.push_back(e);
        busy_from = c + 1;
        free_cyc  = c + 3;
      end else if (sret_req) begin
        e.is_trap = 1'b0;
        e.cyc     = c + 1;
        e.op      = 2'b10;
        e.cause   = 32'h0;
        e.pc      = 32'h0;
        e.val     = 32'h0;
        e.tgt     = continue_addr;
        sb.push_back(e);
        busy_from = c + 1;
        free_cyc  = c + 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      chk("stall", 32'(stall), 32'((cyc >= busy_from) && (cyc < free_cyc)));
      if (trap || redirect) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse at cycle %0d: trap=%0b redirect=%0b expected none",
                   cyc, trap, redirect);
        end else begin
          e = sb.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          chk("event_kind", 32'(trap), 32'(e.is_trap));
          chk("status_op", 32'(status_op), 32'(e.op));
          if (e.is_trap) begin
            chk("trap_cause", trap_cause, e.cause);
            chk("trap_pc", trap_pc, e.pc);
            chk("trap_value", trap_value, e.val);
            chk("redirect_during_trap", 32'(redirect), 32'h0);
          end else begin
            chk("redirect_pc", redirect_pc, e.tgt);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse at cycle %0d: got none expected event due at cycle %0d",
                 cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic quiet();
    inst_done = 1'b0;
    exc_req   = 1'b0;
    sret_req  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trap"}, 32'(trap), 32'h0);
    chk({tag, "_redirect"}, 32'(redirect), 32'h0);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    chk({tag, "_status_op"}, 32'(status_op), 32'h0);
    chk({tag, "_trap_cause"}, trap_cause, 32'h0);
    chk({tag, "_trap_pc"}, trap_pc, 32'h0);
    chk({tag, "_trap_value"}, trap_value, 32'h0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    quiet();
    inst_pc = '0; inst_next_pc = '0; exc_cause = '0; exc_value = '0;
    irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0; sstatus_sie = 1'b0;
    sie_mask = '0; handler_addr = '0; continue_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    drive_cycle();

    // Exception
    handler_addr = 32'h8000; inst_pc = 32'h100; exc_value = 32'hDEAD;
    exc_cause = 5'd2; exc_req = 1'b1; inst_done = 1'b1;
    drive_cycle();
    quiet();
    chk("exc_trap", 32'(trap), 32'h1);
    chk("exc_cause", trap_cause, 32'h2);
    chk("exc_pc", trap_pc, 32'h100);
    chk("exc_value", trap_value, 32'hDEAD);
    chk("exc_status_op", 32'(status_op), 32'h1);
    drive_cycle();
    chk("exc_redirect", 32'(redirect), 32'h1);
    chk("exc_redirect_pc", redirect_pc, 32'h8000);
    drive_cycle();

    // Vectored timer interrupt
    sstatus_sie = 1'b1; sie_mask = 32'h20; irq_timer = 1'b1;
    handler_addr = 32'h8001; inst_next_pc = 32'h204; inst_done = 1'b1;
    drive_cycle();
    quiet(); irq_timer = 1'b0;
    chk("tmr_cause", trap_cause, 32'h8000_0005);
    chk("tmr_pc", trap_pc, 32'h204);
    chk("tmr_value", trap_value, 32'h0);
    drive_cycle();
    chk("tmr_redirect_pc", redirect_pc, 32'h8014);
    drive_cycle();

    // sret
    continue_addr = 32'h300; sret_req = 1'b1; inst_done = 1'b1;
    drive_cycle();
    quiet();
    chk("sret_status_op", 32'(status_op), 32'h2);
    chk("sret_redirect", 32'(redirect), 32'h1);
    chk("sret_redirect_pc", redirect_pc, 32'h300);
    chk("sret_trap", 32'(trap), 32'h0);
    drive_cycle();
    chk("sret_idle_stall", 32'(stall), 32'h0);

    // Reset during SAVE aborts the sequence
    handler_addr = 32'h8000; exc_req = 1'b1; exc_cause = 5'd4; inst_done = 1'b1;
    drive_cycle();
    quiet();
    rst = 1'b1;
    #1;
    chk_all_zero("rst_save");
    sb.delete();
    free_cyc = 0;
    busy_from = 0;
    drive_cycle();
    drive_cycle();
    rst = 1'b0;
    drive_cycle();
    drive_cycle();
    exc_req = 1'b1; exc_cause = 5'd13; inst_pc = 32'h440; exc_value = 32'h1234; inst_done = 1'b1;
    drive_cycle();
    quiet();
    chk("post_rst_cause", trap_cause, 32'hD);
    drive_cycle();
    drive_cycle();

    // Synchronizer latency on irq_ext
    handler_addr = 32'h9000; sie_mask = 32'h200; sstatus_sie = 1'b1;
    irq_ext = 1'b1; inst_done = 1'b1;
    r = cyc;
    for (int k = 0; k < S + 4; k++) begin
      drive_cycle();
      if (trap) break;
    end
    quiet();
    chk("sync_latency", 32'(cyc - r), 32'(S + 1));
    chk("sync_cause", trap_cause, 32'h8000_0009);
    drive_cycle();
    drive_cycle();

    // Priority: all interrupts pending, then with an exception, then SIE off
    irq_soft = 1'b1; irq_timer = 1'b1; sie_mask = 32'h222; inst_done = 1'b1;
    drive_cycle();
    quiet();
    chk("prio_irq_cause", trap_cause, 32'h8000_0009);
    drive_cycle();
    drive_cycle();
    exc_req = 1'b1; exc_cause = 5'd7; inst_done = 1'b1;
    drive_cycle();
    quiet();
    chk("prio_exc_cause", trap_cause, 32'h7);
    drive_cycle();
    drive_cycle();
    sstatus_sie = 1'b0; inst_done = 1'b1;
    drive_cycle();
    chk("sie_off_stall", 32'(stall), 32'h0);
    drive_cycle();
    chk("sie_off_stall2", 32'(stall), 32'h0);
    quiet(); irq_ext = 1'b0; irq_soft = 1'b0; irq_timer = 1'b0;
    repeat (S + 1) drive_cycle();

    // Randomized boundaries
    for (int i = 0; i < 2000; i++) begin
      if (cyc >= free_cyc) begin
        handler_addr  = $urandom;
        continue_addr = $urandom;
      end
      inst_done    = ($urandom_range(1, 0) == 1);
      exc_req      = ($urandom_range(3, 0) == 0);
      sret_req     = ($urandom_range(3, 0) == 0);
      exc_cause    = 5'($urandom);
      exc_value    = $urandom;
      inst_pc      = $urandom;
      inst_next_pc = $urandom;
      if ($urandom_range(15, 0) == 0) irq_ext = ~irq_ext;
      irq_soft     = ($urandom_range(4, 0) == 0);
      irq_timer    = ($urandom_range(4, 0) == 0);
      sstatus_sie  = ($urandom_range(3, 0) != 0);
      sie_mask     = $urandom;
      drive_cycle();
    end
    quiet();
    repeat (6) drive_cycle();
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
